// File: rtl/pipelined_control_unit_if.sv
// pipelined_control_unit_if
//   Fetch-side instruction handshake plus the registered control word that
//   goes to the datapath.
//   master : instruction source (fetch). It drives instr_valid, opcode, funct
//            and branch, and observes everything else.
//   slave  : pipelined_control_unit. It accepts the instruction and drives
//            the control word, the MDU status and the hazard stall.
interface pipelined_control_unit_if #(
    parameter int ALU_CTRL_W = 4
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic                  branch;

    logic                  ctrl_valid;
    logic                  rf_we;
    logic [1:0]            sel_wa;
    logic                  sel_alu_b;
    logic                  dmem_we;
    logic [1:0]            sel_result;
    logic [1:0]            sel_pc;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  mdu_start;
    logic                  mdu_busy;
    logic                  illegal_instr;
    logic                  stall;

    modport master (
        output instr_valid, opcode, funct, branch,
        input  instr_ready, ctrl_valid, rf_we, sel_wa, sel_alu_b, dmem_we,
               sel_result, sel_pc, alu_ctrl, mdu_start, mdu_busy,
               illegal_instr, stall
    );

    modport slave (
        input  instr_valid, opcode, funct, branch,
        output instr_ready, ctrl_valid, rf_we, sel_wa, sel_alu_b, dmem_we,
               sel_result, sel_pc, alu_ctrl, mdu_start, mdu_busy,
               illegal_instr, stall
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit
//   Registered MIPS main/ALU decoder with a one-instruction-per-cycle
//   valid/ready front end, a MULTU/DIVU occupancy sequencer and a HI/LO
//   hazard stall. Undefined opcodes are accepted and leave as a flagged,
//   side-effect-free control word.
// Ports
//   clk   : clock
//   rst_n : asynchronous active-low reset, released on the next clk edge
//   bus   : pipelined_control_unit_if.slave
//           in  instr_valid, opcode[5:0], funct[5:0], branch
//           out instr_ready, stall, ctrl_valid, rf_we, sel_wa[1:0],
//               sel_alu_b, dmem_we, sel_result[1:0], sel_pc[1:0],
//               alu_ctrl[ALU_CTRL_W-1:0], mdu_start, mdu_busy, illegal_instr
// Parameters
//   MULT_CYCLES : cycles MULTU keeps the MDU busy (>= 1)
//   DIV_CYCLES  : cycles DIVU keeps the MDU busy (>= 1)
//   ALU_CTRL_W  : alu_ctrl width, must match the interface instance
module pipelined_control_unit #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int ALU_CTRL_W  = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    pipelined_control_unit_if.slave bus
);

    // Control word layout; these constants are the control_signals words.
    // sel_wa     : 0 rt, 1 rd, 2 $ra
    // sel_result : 0 alu, 1 memory, 2 pc+4 (link)
    // sel_pc     : 0 pc+4, 1 branch target, 2 jump target, 3 register
    // alu_op     : 00 add, 01 subtract, 10 decode from funct
    typedef struct packed {
        logic       rf_we;
        logic [1:0] sel_wa;
        logic       sel_alu_b;
        logic       dmem_we;
        logic [1:0] sel_result;
        logic [1:0] sel_pc;
    } dp_ctrl_t;

    typedef struct packed {
        dp_ctrl_t   dp;
        logic [1:0] alu_op;
    } ctrl_t;

    //                                 rf wa b  we res pc  op
    localparam ctrl_t LWc    = 11'b1_00_1_0_01_00_00;
    localparam ctrl_t SWc    = 11'b0_00_1_1_00_00_00;
    localparam ctrl_t ADDIc  = 11'b1_00_1_0_00_00_00;
    localparam ctrl_t Jc     = 11'b0_00_0_0_00_10_00;
    localparam ctrl_t JALc   = 11'b1_10_0_0_10_10_00;
    localparam ctrl_t BEQc   = 11'b0_00_0_0_00_01_01;
    localparam ctrl_t BEQNc  = 11'b0_00_0_0_00_00_01;
    localparam ctrl_t Rc     = 11'b1_01_0_0_00_00_10;
    localparam ctrl_t JRc    = 11'b0_00_0_0_00_11_10;
    localparam ctrl_t MULTUc = 11'b0_00_0_0_00_00_10;
    localparam ctrl_t DIVUc  = 11'b0_00_0_0_00_00_10;
    localparam ctrl_t ILLc   = 11'b0_00_0_0_00_00_00;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_NOP    = 6'h00;
    localparam logic [5:0] F_SRL    = 6'h02;
    localparam logic [5:0] F_JR     = 6'h08;
    localparam logic [5:0] F_MFHI   = 6'h10;
    localparam logic [5:0] F_MFLO   = 6'h12;
    localparam logic [5:0] F_MULTU  = 6'h19;
    localparam logic [5:0] F_DIVU   = 6'h1B;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_SLT    = 6'h2A;

    localparam logic [3:0] ADDac       = 4'd0;
    localparam logic [3:0] SUBac       = 4'd1;
    localparam logic [3:0] ANDac       = 4'd2;
    localparam logic [3:0] ORac        = 4'd3;
    localparam logic [3:0] SLTac       = 4'd4;
    localparam logic [3:0] SRLac       = 4'd5;
    localparam logic [3:0] MULTUac     = 4'd6;
    localparam logic [3:0] DIVUac      = 4'd7;
    localparam logic [3:0] MFHIac      = 4'd8;
    localparam logic [3:0] MFLOac      = 4'd9;
    localparam logic [3:0] JRac        = 4'd10;
    localparam logic [3:0] NOPac       = 4'd11;
    localparam logic [3:0] ADDIac      = 4'd12;
    localparam logic [3:0] SUBIac      = 4'd13;
    localparam logic [3:0] DONT_CAREac = 4'd15;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    ctrl_t                 dec_word;
    logic [3:0]            dec_alu;
    logic                  dec_illegal;
    logic                  dec_mdu;
    logic                  dec_div;
    logic                  hazard;
    logic                  ready;
    logic                  accept;

    logic                  run_q;
    logic                  valid_q;
    dp_ctrl_t              dp_q;
    logic [ALU_CTRL_W-1:0] alu_q;
    logic                  illegal_q;
    logic                  start_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  mdu_busy;

    always_comb begin
        dec_word    = ILLc;
        dec_illegal = 1'b0;
        dec_mdu     = 1'b0;
        dec_div     = 1'b0;
        case (bus.opcode)
            OP_LW:   dec_word = LWc;
            OP_SW:   dec_word = SWc;
            OP_ADDI: dec_word = ADDIc;
            OP_J:    dec_word = Jc;
            OP_JAL:  dec_word = JALc;
            OP_BEQ:  dec_word = bus.branch ? BEQc : BEQNc;
            OP_RTYPE: begin
                case (bus.funct)
                    F_JR:    dec_word = JRc;
                    F_MULTU: begin
                        dec_word = MULTUc;
                        dec_mdu  = 1'b1;
                    end
                    F_DIVU: begin
                        dec_word = DIVUc;
                        dec_mdu  = 1'b1;
                        dec_div  = 1'b1;
                    end
                    default: dec_word = Rc;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // An illegal opcode carries alu_op 00 in ILLc, so it must be forced to
    // DONT_CARE explicitly rather than falling into the ADDI slot.
    always_comb begin
        dec_alu = DONT_CAREac;
        if (!dec_illegal) begin
            case (dec_word.alu_op)
                2'b00:   dec_alu = ADDIac;
                2'b01:   dec_alu = SUBIac;
                default: begin
                    case (bus.funct)
                        F_ADD:   dec_alu = ADDac;
                        F_AND:   dec_alu = ANDac;
                        F_DIVU:  dec_alu = DIVUac;
                        F_JR:    dec_alu = JRac;
                        F_MFHI:  dec_alu = MFHIac;
                        F_MFLO:  dec_alu = MFLOac;
                        F_MULTU: dec_alu = MULTUac;
                        F_NOP:   dec_alu = NOPac;
                        F_OR:    dec_alu = ORac;
                        F_SLT:   dec_alu = SLTac;
                        F_SRL:   dec_alu = SRLac;
                        F_SUB:   dec_alu = SUBac;
                        default: dec_alu = DONT_CAREac;
                    endcase
                end
            endcase
        end
    end

    // Instructions that touch HI/LO or the MDU itself must wait out the MDU.
    assign hazard = (bus.opcode == OP_RTYPE) &&
                    ((bus.funct == F_MULTU) || (bus.funct == F_DIVU) ||
                     (bus.funct == F_MFHI)  || (bus.funct == F_MFLO));

    assign mdu_busy = (cnt_q != '0);

    // run_q holds ready low until the first edge after reset release, so
    // every output, ready included, reads 0 while rst_n is asserted.
    assign ready  = run_q && !(mdu_busy && hazard);
    assign accept = bus.instr_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            valid_q   <= 1'b0;
            dp_q      <= '0;
            alu_q     <= '0;
            illegal_q <= 1'b0;
            start_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            run_q     <= 1'b1;
            valid_q   <= accept;
            dp_q      <= accept ? dec_word.dp : '0;
            alu_q     <= accept ? ALU_CTRL_W'(dec_alu) : '0;
            illegal_q <= accept && dec_illegal;
            start_q   <= accept && dec_mdu;
            // A new MDU op is never accepted while busy, so load cannot
            // collide with an in-flight count.
            if (accept && dec_mdu) begin
                cnt_q <= dec_div ? DIV_LOAD : MULT_LOAD;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign bus.instr_ready   = ready;
    assign bus.stall         = bus.instr_valid && run_q && !ready;
    assign bus.ctrl_valid    = valid_q;
    assign bus.rf_we         = dp_q.rf_we;
    assign bus.sel_wa        = dp_q.sel_wa;
    assign bus.sel_alu_b     = dp_q.sel_alu_b;
    assign bus.dmem_we       = dp_q.dmem_we;
    assign bus.sel_result    = dp_q.sel_result;
    assign bus.sel_pc        = dp_q.sel_pc;
    assign bus.alu_ctrl      = alu_q;
    assign bus.mdu_start     = start_q;
    assign bus.mdu_busy      = mdu_busy;
    assign bus.illegal_instr = illegal_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit
//   Directed and random stimulus against a behavioural model of the decoder
//   and the MDU occupancy window; a second small instance covers the
//   single-cycle MULTU boundary.
module tb_pipelined_control_unit;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    localparam logic [3:0] AC_ADD = 4'd0,  AC_SUB = 4'd1,  AC_AND = 4'd2,  AC_OR = 4'd3;
    localparam logic [3:0] AC_SLT = 4'd4,  AC_SRL = 4'd5,  AC_MULTU = 4'd6, AC_DIVU = 4'd7;
    localparam logic [3:0] AC_MFHI = 4'd8, AC_MFLO = 4'd9, AC_JR = 4'd10,  AC_NOP = 4'd11;
    localparam logic [3:0] AC_ADDI = 4'd12, AC_SUBI = 4'd13, AC_DC = 4'd15;

    typedef struct packed {
        logic       rf_we;
        logic [1:0] sel_wa;
        logic       sel_alu_b;
        logic       dmem_we;
        logic [1:0] sel_result;
        logic [1:0] sel_pc;
        logic [3:0] alu;
        logic       ill;
        logic [1:0] mdu;   // 0 none, 1 multu, 2 divu
    } ref_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pipelined_control_unit_if #(.ALU_CTRL_W(4)) bus ();
    pipelined_control_unit_if #(.ALU_CTRL_W(4)) bus_s ();

    pipelined_control_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .ALU_CTRL_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pipelined_control_unit #(.MULT_CYCLES(1), .DIV_CYCLES(2), .ALU_CTRL_W(4)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    int          checks = 0;
    int          errors = 0;
    int          t;
    int          busy_end;
    bit          run;
    logic [14:0] exp_ctrl;
    logic        exp_start;
    bit          last_stall;
    logic [5:0]  fn_list [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h02,
                                  6'h00, 6'h08, 6'h10, 6'h12, 6'h19, 6'h1B};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [3:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            6'h20: return AC_ADD;
            6'h22: return AC_SUB;
            6'h24: return AC_AND;
            6'h25: return AC_OR;
            6'h2A: return AC_SLT;
            6'h02: return AC_SRL;
            6'h00: return AC_NOP;
            6'h08: return AC_JR;
            6'h10: return AC_MFHI;
            6'h12: return AC_MFLO;
            6'h19: return AC_MULTU;
            6'h1B: return AC_DIVU;
            default: return AC_DC;
        endcase
    endfunction

    // What each instruction is supposed to do to the datapath.
    function automatic ref_t ref_decode(input logic [5:0] op, input logic [5:0] fn, input logic br);
        ref_t r;
        r     = '0;
        r.alu = AC_ADDI;
        case (op)
            6'h23: begin r.rf_we = 1; r.sel_alu_b = 1; r.sel_result = 2'd1; end
            6'h2B: begin r.sel_alu_b = 1; r.dmem_we = 1; end
            6'h08: begin r.rf_we = 1; r.sel_alu_b = 1; end
            6'h02: r.sel_pc = 2'd2;
            6'h03: begin r.rf_we = 1; r.sel_wa = 2'd2; r.sel_result = 2'd2; r.sel_pc = 2'd2; end
            6'h04: begin r.alu = AC_SUBI; r.sel_pc = br ? 2'd1 : 2'd0; end
            6'h00: begin
                r.alu = rtype_alu(fn);
                if (fn == 6'h08)      r.sel_pc = 2'd3;
                else if (fn == 6'h19) r.mdu = 2'd1;
                else if (fn == 6'h1B) r.mdu = 2'd2;
                else begin r.rf_we = 1; r.sel_wa = 2'd1; end
            end
            default: begin r.ill = 1; r.alu = AC_DC; end
        endcase
        return r;
    endfunction

    // One clock cycle: present inputs after the falling edge, compare every
    // output against the model, then advance the model across the rising edge.
    task automatic cycle(input bit v, input logic [5:0] op, input logic [5:0] fn, input bit br);
        bit   busy, haz, rdy, acc;
        ref_t r;
        bus.instr_valid = v;
        bus.opcode      = op;
        bus.funct       = fn;
        bus.branch      = br;
        #1;
        busy = (t <= busy_end);
        haz  = (op == 6'h00) && (fn == 6'h19 || fn == 6'h1B || fn == 6'h10 || fn == 6'h12);
        rdy  = run && !(busy && haz);
        acc  = v && rdy;
        check($sformatf("ctrl_word_c%0d", t),
              {17'b0, bus.ctrl_valid, bus.rf_we, bus.sel_wa, bus.sel_alu_b, bus.dmem_we,
               bus.sel_result, bus.sel_pc, bus.alu_ctrl, bus.illegal_instr},
              {17'b0, exp_ctrl});
        check($sformatf("rdy_stall_busy_start_c%0d", t),
              {28'b0, bus.instr_ready, bus.stall, bus.mdu_busy, bus.mdu_start},
              {28'b0, rdy, v && !rdy && run, busy, exp_start});
        last_stall = bus.stall;
        if (acc) begin
            r         = ref_decode(op, fn, br);
            exp_ctrl  = {1'b1, r.rf_we, r.sel_wa, r.sel_alu_b, r.dmem_we, r.sel_result,
                         r.sel_pc, r.alu, r.ill};
            exp_start = (r.mdu != 2'd0);
            if (r.mdu == 2'd1)      busy_end = t + MULT_N;
            else if (r.mdu == 2'd2) busy_end = t + DIV_N;
        end else begin
            exp_ctrl  = '0;
            exp_start = 1'b0;
        end
        run = (rst_n === 1'b1);
        @(negedge clk);
        t++;
    endtask

    task automatic async_reset_mid();
        bus.instr_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_outputs",
              {13'b0, bus.ctrl_valid, bus.rf_we, bus.sel_wa, bus.sel_alu_b, bus.dmem_we,
               bus.sel_result, bus.sel_pc, bus.alu_ctrl, bus.illegal_instr,
               bus.instr_ready, bus.stall, bus.mdu_busy, bus.mdu_start}, 32'd0);
        run       = 1'b0;
        busy_end  = -1;
        exp_ctrl  = '0;
        exp_start = 1'b0;
        @(negedge clk);
        t++;
    endtask

    initial begin
        int         nst;
        bit         v, br;
        logic [5:0] op, fn;
        int         k;

        bus.instr_valid = 0; bus.opcode = 0; bus.funct = 0; bus.branch = 0;
        bus_s.instr_valid = 0; bus_s.opcode = 0; bus_s.funct = 0; bus_s.branch = 0;
        t = 0; busy_end = -1; run = 0; exp_ctrl = '0; exp_start = 0;

        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("reset_state",
              {13'b0, bus.ctrl_valid, bus.rf_we, bus.sel_wa, bus.sel_alu_b, bus.dmem_we,
               bus.sel_result, bus.sel_pc, bus.alu_ctrl, bus.illegal_instr,
               bus.instr_ready, bus.stall, bus.mdu_busy, bus.mdu_start}, 32'd0);
        cycle(0, 6'h00, 6'h00, 0);
        cycle(0, 6'h00, 6'h00, 0);
        rst_n = 1'b1;
        cycle(0, 6'h00, 6'h00, 0);
        cycle(0, 6'h00, 6'h00, 0);

        // ADD, then a bubble
        cycle(1, 6'h00, 6'h20, 0);
        check("add_result", {29'b0, bus.ctrl_valid, bus.rf_we, 1'b0} | {28'b0, bus.alu_ctrl},
              {29'b0, 1'b1, 1'b1, 1'b0} | {28'b0, AC_ADD});
        cycle(0, 6'h00, 6'h00, 0);
        check("add_bubble", {27'b0, bus.ctrl_valid, bus.rf_we, bus.dmem_we, bus.mdu_start,
              bus.illegal_instr} | {30'b0, bus.sel_pc}, 32'd0);

        // LW, SW, BEQ taken, BEQ not taken back to back
        cycle(1, 6'h23, 6'h11, 0);
        cycle(1, 6'h2B, 6'h05, 0);
        cycle(1, 6'h04, 6'h00, 1);
        cycle(1, 6'h04, 6'h00, 0);
        check("beq_not_taken_pc", {30'b0, bus.sel_pc}, 32'd0);
        cycle(1, 6'h02, 6'h00, 0);
        cycle(1, 6'h03, 6'h00, 0);
        cycle(1, 6'h00, 6'h08, 0);
        cycle(0, 6'h00, 6'h00, 0);

        // MULTU then MFHI held by the hazard
        cycle(1, 6'h00, 6'h19, 0);
        nst = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1, 6'h00, 6'h10, 0);
            if (last_stall) nst++;
        end
        check("mfhi_stall_cycles", nst, 4);
        check("mfhi_issue", {27'b0, bus.ctrl_valid, bus.alu_ctrl}, {27'b0, 1'b1, AC_MFHI});
        cycle(0, 6'h00, 6'h00, 0);

        // undefined opcode
        cycle(1, 6'h3F, 6'h2A, 1);
        check("illegal_word", {24'b0, bus.ctrl_valid, bus.illegal_instr, bus.rf_we, bus.dmem_we,
              bus.sel_pc, 2'b00} | {28'b0, bus.alu_ctrl},
              {24'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00} | {28'b0, AC_DC});
        cycle(0, 6'h00, 6'h00, 0);

        // DIVU, overlapping ADDI, reset when the counter reads 20
        cycle(1, 6'h00, 6'h1B, 0);
        cycle(1, 6'h08, 6'h00, 0);
        check("addi_overlap", {29'b0, bus.ctrl_valid, bus.mdu_busy, bus.stall}, {29'b0, 3'b110});
        for (int i = 0; i < 11; i++) cycle(0, 6'h00, 6'h00, 0);
        check("div_busy_before_reset", {31'b0, bus.mdu_busy}, 32'd1);
        async_reset_mid();
        cycle(0, 6'h00, 6'h00, 0);
        rst_n = 1'b1;
        cycle(0, 6'h00, 6'h00, 0);
        cycle(1, 6'h00, 6'h12, 0);
        check("mflo_after_reset", {27'b0, bus.ctrl_valid, bus.alu_ctrl}, {27'b0, 1'b1, AC_MFLO});
        cycle(0, 6'h00, 6'h00, 0);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0, 1, 2: op = 6'h00;
                3:       op = 6'h23;
                4:       op = 6'h2B;
                5:       op = 6'h08;
                6:       op = 6'h02;
                7:       op = 6'h03;
                8:       op = 6'h04;
                default: op = 6'($urandom);
            endcase
            k  = $urandom_range(0, 13);
            fn = (k < 12) ? fn_list[k] : 6'($urandom);
            br = 1'($urandom);
            cycle(v, op, fn, br);
        end
        cycle(0, 6'h00, 6'h00, 0);

        // MULT_CYCLES=1 / DIV_CYCLES=2 instance
        bus_s.instr_valid = 1; bus_s.opcode = 6'h00; bus_s.funct = 6'h19;
        @(negedge clk);
        bus_s.instr_valid = 0;
        #1;
        check("n1_busy_start", {30'b0, bus_s.mdu_busy, bus_s.mdu_start}, 32'd3);
        @(negedge clk);
        bus_s.instr_valid = 1;
        #1;
        check("n1_second_multu", {29'b0, bus_s.instr_ready, bus_s.stall, bus_s.mdu_busy},
              {29'b0, 3'b100});
        @(negedge clk);
        bus_s.instr_valid = 0;
        #1;
        check("n1_second_busy", {30'b0, bus_s.mdu_busy, bus_s.mdu_start}, 32'd3);
        @(negedge clk);
        bus_s.instr_valid = 1; bus_s.funct = 6'h1B;
        #1;
        check("n2_divu_ready", {31'b0, bus_s.instr_ready}, 32'd1);
        @(negedge clk);
        bus_s.funct = 6'h10;
        #1;
        check("n2_mfhi_stall_a", {30'b0, bus_s.mdu_busy, bus_s.stall}, 32'd3);
        @(negedge clk);
        #1;
        check("n2_mfhi_stall_b", {30'b0, bus_s.mdu_busy, bus_s.stall}, 32'd3);
        @(negedge clk);
        #1;
        check("n2_mfhi_free", {29'b0, bus_s.instr_ready, bus_s.stall, bus_s.mdu_busy},
              {29'b0, 3'b100});
        @(negedge clk);
        bus_s.instr_valid = 0;
        #1;
        check("n2_mfhi_issue", {27'b0, bus_s.ctrl_valid, bus_s.alu_ctrl}, {27'b0, 1'b1, AC_MFHI});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
